// File: rtl/i2s_pkg.sv
// Shared I2S encodings, receiver state type and the word-length helper.
package i2s_pkg;
    localparam logic [1:0] STD_PHILIPS = 2'b00;
    localparam logic [1:0] STD_LJ      = 2'b01;
    localparam logic [1:0] WS16        = 2'b00;
    localparam logic [1:0] WS32        = 2'b01;

    typedef enum logic [1:0] {IDLE, SHIFT_L, SHIFT_R, SHIFT_M} rx_state_t;

    function automatic logic [5:0] word_len(input logic [1:0] word_size);
        return (word_size == WS16) ? 6'd16 : 6'd32;
    endfunction
endpackage

// File: rtl/i2s_rx_shreg.sv
// Serial-in shift register with bit counter; done strobes on the edge that takes the word's last bit.
module i2s_rx_shreg #(
    parameter int W = 32
) (
    input  logic         rclk,
    input  logic         rst,
    input  logic         clr,
    input  logic         shift,
    input  logic         sd,
    input  logic [5:0]   n,
    output logic [W-1:0] word_nxt,
    output logic         done
);
    logic [W-2:0] shreg;
    logic [5:0]   count;

    // word_nxt already includes the bit being sampled, so the word is usable on the done edge.
    assign word_nxt = {shreg, sd};
    assign done     = shift && (count == n - 6'd1);

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            count <= '0;
        end else if (clr || done) begin
            shreg <= '0;
            count <= '0;
        end else begin
            shreg <= word_nxt[W-2:0];
            count <= count + 6'd1;
        end
    end
endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receive deserialiser: locks to ws, assembles L/R (or mono) words, hands frames over valid/ready.
// Defining RX_WS_CHECK_EN adds the ws_err output and re-hunts on a misplaced or missing ws edge.
module i2s_rx_deser
    import i2s_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              en,
    input  logic              stereo,
    input  logic [1:0]        standard,
    input  logic [1:0]        word_size,
    input  logic              sd,
    input  logic              ws,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] doutL,
    output logic [DATA_W-1:0] doutR,
    output logic              dout_valid,
    output logic              locked,
    output logic              overrun,
`ifdef RX_WS_CHECK_EN
    output logic              ws_err,
`endif
    output rx_state_t         state_dbg
);
    // Handshake: dout_valid holds a frame until a posedge with dout_ready=1; a frame completing
    // while dout_valid=1 and dout_ready=0 is dropped and overrun latches.
    rx_state_t         state, state_nxt;
    logic              ws_q, ws_fall, start, start_lj, shift, clr;
    logic              sr_done, word_done, frame_done, ws_bad;
    logic [5:0]        cfg_n;
    logic [DATA_W-1:0] sr_word, left_hold;

    assign ws_fall    = ws_q & ~ws;
    assign start      = en && (state == IDLE) && (stereo ? ws_fall : 1'b1);
    assign start_lj   = start && (standard != STD_PHILIPS);
    assign shift      = en && ((state != IDLE) || start_lj);
    assign clr        = !shift || ws_bad;
    assign word_done  = sr_done && !ws_bad;
    assign frame_done = word_done && ((state == SHIFT_R) || (state == SHIFT_M));

    i2s_rx_shreg #(.W(DATA_W)) u_shreg (
        .rclk     (rclk),
        .rst      (rst),
        .clr      (clr),
        .shift    (shift),
        .sd       (sd),
        .n        (cfg_n),
        .word_nxt (sr_word),
        .done     (sr_done)
    );

`ifdef RX_WS_CHECK_EN
    logic       ws_edge, first_q, exp_edge;
    logic [1:0] cfg_std;

    // Philips moves ws on a word's last bit, left-justified on the first bit of the next word.
    assign ws_edge  = ws ^ ws_q;
    assign exp_edge = (cfg_std == STD_PHILIPS) ? sr_done : first_q;
    assign ws_bad   = en && ((state == SHIFT_L) || (state == SHIFT_R)) && (ws_edge != exp_edge);

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            cfg_std <= STD_PHILIPS;
            first_q <= 1'b0;
            ws_err  <= 1'b0;
        end else begin
            if (start || sr_done) cfg_std <= standard;
            first_q <= sr_done;
            ws_err  <= ws_bad;
        end
    end
`else
    assign ws_bad = 1'b0;
`endif

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en || ws_bad) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)   state_nxt = stereo ? SHIFT_L : SHIFT_M;
                SHIFT_L: if (sr_done) state_nxt = SHIFT_R;
                SHIFT_R: if (sr_done) state_nxt = stereo ? SHIFT_L : IDLE;
                SHIFT_M: if (sr_done) state_nxt = stereo ? IDLE : SHIFT_M;
                default:              state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        locked    = (state != IDLE);
        state_dbg = state;
    end

    // Mode fields are taken only at word boundaries so a mid-word change cannot split a word.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            ws_q       <= 1'b0;
            cfg_n      <= 6'd16;
            left_hold  <= '0;
            doutL      <= '0;
            doutR      <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            ws_q <= ws;
            if (start || sr_done) cfg_n <= word_len(word_size);
            if (word_done && (state == SHIFT_L)) left_hold <= sr_word;
            if (frame_done) begin
                if (!dout_valid || dout_ready) begin
                    doutL      <= (state == SHIFT_R) ? left_hold : sr_word;
                    doutR      <= (state == SHIFT_R) ? sr_word : '0;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_i2s_rx_deser.sv
// Directed bench for i2s_rx_deser: a bit-level transmitter model drives ws/sd on negedge.
module tb_i2s_rx_deser;
    import i2s_pkg::*;

    logic        rclk = 1'b0;
    logic        rst, en, stereo, sd, ws, dout_ready;
    logic [1:0]  standard, word_size;
    logic [31:0] doutL, doutR;
    logic        dout_valid, locked, overrun;
    rx_state_t   state_dbg;
`ifdef RX_WS_CHECK_EN
    logic        ws_err;
    int          wserr_cnt = 0;
`endif
    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    always #5 rclk = ~rclk;

    i2s_rx_deser #(.DATA_W(32)) dut (
        .rclk       (rclk),
        .rst        (rst),
        .en         (en),
        .stereo     (stereo),
        .standard   (standard),
        .word_size  (word_size),
        .sd         (sd),
        .ws         (ws),
        .dout_ready (dout_ready),
        .doutL      (doutL),
        .doutR      (doutR),
        .dout_valid (dout_valid),
        .locked     (locked),
        .overrun    (overrun),
`ifdef RX_WS_CHECK_EN
        .ws_err     (ws_err),
`endif
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bit period: drive on negedge, return 1 time unit after the sampling posedge.
    task automatic tick_bit(input logic w, input logic d);
        @(negedge rclk);
        ws = w;
        sd = d;
        @(posedge rclk);
        #1;
        if (dout_valid) valid_cnt++;
`ifdef RX_WS_CHECK_EN
        if (ws_err) wserr_cnt++;
`endif
    endtask

    task automatic send_head(input logic [31:0] w, input int n, input logic wb);
        for (int i = n - 1; i >= 1; i--) tick_bit(wb, w[i]);
    endtask

    task automatic send_word(input logic [31:0] w, input int n, input logic wb, input logic wl);
        send_head(w, n, wb);
        tick_bit(wl, w[0]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; stereo = 1'b1; standard = STD_PHILIPS; word_size = WS16;
        sd = 1'b0; ws = 1'b0; dout_ready = 1'b0;
        repeat (2) @(negedge rclk);
        check("rst_doutL", doutL, 32'h0);
        check("rst_doutR", doutR, 32'h0);
        check("rst_valid", {31'h0, dout_valid}, 32'h0);
        check("rst_locked", {31'h0, locked}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;
        en  = 1'b1;

        // Stereo Philips 16-bit: ws falls one bit ahead of the left MSB
        tick_bit(1'b1, 1'b0); tick_bit(1'b1, 1'b0); tick_bit(1'b1, 1'b0);
        check("ph_unlocked", {31'h0, locked}, 32'h0);
        tick_bit(1'b0, 1'b0);
        check("ph_lock", {31'h0, locked}, 32'h1);
        send_word(32'h1111, 16, 1'b0, 1'b1);
        send_word(32'h2222, 16, 1'b1, 1'b0);
        check("ph_lead_valid", {31'h0, dout_valid}, 32'h1);
        check("ph_lead_L", doutL, 32'h00001111);
        dout_ready = 1'b1;
        send_word(32'hA5C3, 16, 1'b0, 1'b1);
        send_head(32'h0F0F, 16, 1'b1);
        check("ph_valid_before_lsb", {31'h0, dout_valid}, 32'h0);
        tick_bit(1'b0, 1'b1);
        check("ph_valid_at_lsb", {31'h0, dout_valid}, 32'h1);
        check("ph_doutL", doutL, 32'h0000A5C3);
        check("ph_doutR", doutR, 32'h00000F0F);
        check("ph_locked", {31'h0, locked}, 32'h1);

        // Stereo left-justified 32-bit, consumer always ready
        en = 1'b0;
        tick_bit(1'b1, 1'b0);
        check("en0_idle", {31'h0, locked}, 32'h0);
        standard = STD_LJ; word_size = WS32; en = 1'b1;
        tick_bit(1'b1, 1'b0); tick_bit(1'b1, 1'b0);
        send_word(32'hDEADBEEF, 32, 1'b0, 1'b0);
        send_word(32'h12345678, 32, 1'b1, 1'b1);
        check("lj_f1_valid", {31'h0, dout_valid}, 32'h1);
        check("lj_f1_L", doutL, 32'hDEADBEEF);
        check("lj_f1_R", doutR, 32'h12345678);
        valid_cnt = 0;
        send_word(32'hDEADBEEF, 32, 1'b0, 1'b0);
        send_word(32'h12345678, 32, 1'b1, 1'b1);
        check("lj_valid_pulses", valid_cnt, 32'd1);
        check("lj_f2_L", doutL, 32'hDEADBEEF);
        check("lj_f2_R", doutR, 32'h12345678);
        check("lj_no_overrun", {31'h0, overrun}, 32'h0);

        // Backpressure: two frames complete while dout_ready=0
        send_word(32'hCAFEF00D, 32, 1'b0, 1'b0);
        dout_ready = 1'b0;
        send_word(32'h0BADC0DE, 32, 1'b1, 1'b1);
        check("bp_a_valid", {31'h0, dout_valid}, 32'h1);
        check("bp_a_L", doutL, 32'hCAFEF00D);
        check("bp_a_R", doutR, 32'h0BADC0DE);
        check("bp_a_overrun", {31'h0, overrun}, 32'h0);
        send_word(32'h11223344, 32, 1'b0, 1'b0);
        send_word(32'h55667788, 32, 1'b1, 1'b1);
        check("bp_b_overrun", {31'h0, overrun}, 32'h1);
        check("bp_b_valid", {31'h0, dout_valid}, 32'h1);
        check("bp_b_L_held", doutL, 32'hCAFEF00D);
        check("bp_b_R_held", doutR, 32'h0BADC0DE);

        // Asynchronous reset mid-word, then relock
        for (int i = 31; i >= 16; i--) tick_bit(1'b0, i[0]);
        #2 rst = 1'b1;
        #1;
        check("arst_doutL", doutL, 32'h0);
        check("arst_doutR", doutR, 32'h0);
        check("arst_valid", {31'h0, dout_valid}, 32'h0);
        check("arst_locked", {31'h0, locked}, 32'h0);
        check("arst_overrun", {31'h0, overrun}, 32'h0);
        tick_bit(1'b1, 1'b0); tick_bit(1'b1, 1'b0);
        #2 rst = 1'b0;
        dout_ready = 1'b1;
        tick_bit(1'b1, 1'b0); tick_bit(1'b1, 1'b0);
        send_word(32'hA1B2C3D4, 32, 1'b0, 1'b0);
        send_word(32'h55AA33CC, 32, 1'b1, 1'b1);
        check("relock_valid", {31'h0, dout_valid}, 32'h1);
        check("relock_L", doutL, 32'hA1B2C3D4);
        check("relock_R", doutR, 32'h55AA33CC);

        // Mono 16-bit left-justified: first bit sampled with en=1 is the MSB
        en = 1'b0;
        tick_bit(1'b0, 1'b0);
        stereo = 1'b0; word_size = WS16; standard = STD_LJ; en = 1'b1;
        send_word(32'h8001, 16, 1'b0, 1'b0);
        check("mono1_valid", {31'h0, dout_valid}, 32'h1);
        check("mono1_L", doutL, 32'h00008001);
        check("mono1_R", doutR, 32'h0);
        check("mono_state", 32'(state_dbg), 32'(SHIFT_M));
        send_head(32'h7FFE, 16, 1'b0);
        check("mono2_valid_before", {31'h0, dout_valid}, 32'h0);
        tick_bit(1'b0, 1'b0);
        check("mono2_valid", {31'h0, dout_valid}, 32'h1);
        check("mono2_L", doutL, 32'h00007FFE);
        check("mono2_R", doutR, 32'h0);
        check("mono_locked", {31'h0, locked}, 32'h1);

`ifdef RX_WS_CHECK_EN
        check("no_spurious_ws_err", wserr_cnt, 32'd0);
        en = 1'b0;
        tick_bit(1'b1, 1'b0);
        stereo = 1'b1; standard = STD_PHILIPS; word_size = WS16; en = 1'b1;
        tick_bit(1'b1, 1'b0); tick_bit(1'b0, 1'b0);
        send_word(32'h3C3C, 16, 1'b0, 1'b1);
        send_word(32'hC3C3, 16, 1'b1, 1'b0);
        check("wc_good_L", doutL, 32'h00003C3C);
        for (int i = 15; i >= 4; i--) tick_bit(1'b0, 1'b1);
        tick_bit(1'b1, 1'b1);
        check("wc_ws_err", {31'h0, ws_err}, 32'h1);
        check("wc_unlocked", {31'h0, locked}, 32'h0);
        tick_bit(1'b1, 1'b1);
        check("wc_ws_err_pulse", {31'h0, ws_err}, 32'h0);
        tick_bit(1'b1, 1'b1); tick_bit(1'b1, 1'b1);
        wserr_cnt = 0;
        tick_bit(1'b0, 1'b0);
        check("wc_relock", {31'h0, locked}, 32'h1);
        check("wc_discard_valid", {31'h0, dout_valid}, 32'h0);
        check("wc_discard_L", doutL, 32'h00003C3C);
        send_word(32'h1234, 16, 1'b0, 1'b1);
        send_word(32'h5678, 16, 1'b1, 1'b0);
        check("wc_new_L", doutL, 32'h00001234);
        check("wc_new_R", doutR, 32'h00005678);
        check("wc_no_err_after", wserr_cnt, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- Receive-side stage directly downstream of the I2S transmit FIFO.
- Samples the serial data line sd and word-select ws on the bit clock and assembles words into left/right 32-bit registers.
- Hands each completed frame to the consumer with a valid/ready handshake.
- Mode controls are shared with the transmitter: stereo, standard, word_size.

Parameters:
- DATA_W, 32, width of the doutL/doutR output words.

Ports:
- rclk  in  1  bit clock; sd and ws sampled on posedge (the transmitter drives on negedge).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  receiver enable.
- stereo  in  1  1 = L/R frames, 0 = mono.
- standard  in  2  00 = Philips (ws leads MSB by one bit); others = left-justified (ws changes with MSB).
- word_size  in  2  00 = 16-bit word; other values = 32-bit word.
- sd  in  1  serial data, MSB first.
- ws  in  1  word select; 0 = left, 1 = right.
- dout_ready  in  1  consumer accepts frame.
- doutL  out  DATA_W  left word, right-aligned, upper bits zero for 16-bit words.
- doutR  out  DATA_W  right word; 0 in mono.
- dout_valid  out  1  frame available.
- locked  out  1  aligned to the frame.
- overrun  out  1  sticky; a frame was lost.

Behaviour:
- Reset values: doutL=0, doutR=0, dout_valid=0, locked=0, overrun=0, state IDLE, ws_q=0, bit counter=0.
- Signals rst clears:
  - overrun is cleared only by rst.
  - When en=0, the state returns to IDLE and the partial word is discarded.
  - en=0 does not affect dout_valid, doutL/doutR or overrun.
- Sampling: every posedge samples sd and ws; ws_q holds the previous ws sample.
- A ws edge is any sample where ws != ws_q.
- N = 16 when word_size=00, otherwise 32. stereo, standard and word_size are latched on leaving IDLE and at each word start; changes mid-word are ignored.
- State IDLE:
  - Stereo: wait for a falling ws edge (right to left).
  - Left-justified: the sd sampled on that edge is the left MSB. Enter SHIFT_L with count=1.
  - Philips: enter SHIFT_L with count=0; the MSB is sampled on the following edge.
  - Mono: enter SHIFT_M on the first posedge with en=1. Philips mode skips one bit first.
- SHIFT_L / SHIFT_R / SHIFT_M: shift sd into the LSB of the shift register each posedge.
- Word completion: when count reaches N, the word completes.
  - SHIFT_L: stores into the left holding register, then goes to SHIFT_R.
  - SHIFT_R: goes to SHIFT_L.
  - SHIFT_M: stays in SHIFT_M.
- Words run back-to-back with no gap. locked=1 in every SHIFT state.
- Frame complete: on completion of SHIFT_R, or of each SHIFT_M word.
  - If dout_valid=0, or dout_valid=1 and dout_ready=1 on the same edge: load doutL/doutR, dout_valid=1.
  - If dout_valid=1 and dout_ready=0: keep old data, set overrun=1, drop the new frame.
- dout_ready=1 with no frame completing clears dout_valid.
- Latency: dout_valid rises on the posedge that samples the right LSB.
- The first partial frame after lock-in is never output.

Optional Feature:
- RX_WS_CHECK_EN defined, stereo only: ws must change exactly at the expected bit.
  - Philips: at the last bit of a word.
  - Left-justified: at the first bit of a word.
  - An unexpected ws edge, or a missing one, pulses ws_err (extra 1-bit output port) for one cycle.
  - On the error, locked drops to 0, the current frame is discarded, and the block re-enters IDLE hunting.
- Not defined: ws is only used for the initial lock, later edges are ignored, and there is no ws_err port.

Decomposition:
- Package i2s_pkg:
  - standard encodings STD_PHILIPS=2'b00 and STD_LJ;
  - word-size encodings WS16=2'b00 and WS32;
  - rx_state_t enum {IDLE, SHIFT_L, SHIFT_R, SHIFT_M};
  - function word_len(word_size) returning 16 or 32.
- One natural sub-module, i2s_rx_shreg: shift register plus bit counter, with a word-done strobe.

Test Plan:
- Stereo, Philips, 16-bit: transmitter model sends L=16'hA5C3, R=16'h0F0F after one lead-in frame → doutL=32'h0000A5C3, doutR=32'h00000F0F, dout_valid rises on the R-LSB edge, locked=1.
- Stereo, left-justified, 32-bit: L=32'hDEADBEEF, R=32'h12345678, dout_ready held 1 → consecutive frames delivered, dout_valid pulses once per 64 bits, no overrun.
- Backpressure: dout_ready=0 across two completed frames → first frame held unchanged, overrun=1 after the second; rst → overrun=0, dout_valid=0.
- Mono, 16-bit: en raised, stream 16'h8001, 16'h7FFE → two frames on doutL, doutR=0.
- rst asserted mid-word asynchronously (not aligned to rclk) → all outputs zero immediately; after release, relock on the next ws fall and receive a correct frame.
- RX_WS_CHECK_EN defined, ws edge injected 3 bits early → ws_err pulses, locked=0, frame discarded, relock on the next ws fall.
